seg_display_scanner: RTL and testbench
======================================

// Module: seg_display_scanner
// PURPOSE
//  Time-multiplexed scan driver for the 4-digit 7-segment display. Holds four 4-bit digits and
//  four dot flags, and steps a digit index at a programmable refresh rate. Each step presents
//  the selected digit's code, dot and index to the downstream 7-segment decoder.
//  New display values are double-buffered. They are committed only at a frame boundary, so a
//  frame never shows a mix of old and new digits (no tearing).
// PARAMETERS
//  CLK_DIV  100000  CLK cycles per digit step; legal range >=1; 1 means step every enabled cycle
// PORTS
//  CLK             in   1   system clock; all state updates on rising edge
//  RESET           in   1   synchronous, active-high reset
//  ENABLE          in   1   1 = scan runs; 0 = prescaler and digit index frozen
//  LOAD            in   1   1-cycle strobe: capture DIGITS_IN/DOTS_IN into the pending buffer
//  DIGITS_IN       in   16  digit n = DIGITS_IN[4n+3:4n]; digit 0 is rightmost
//  DOTS_IN         in   4   DOTS_IN[n] = dot for digit n (1 = lit)
//  SEG_SELECT_OUT  out  2   index of the digit currently presented
//  BIN_OUT         out  4   code of the digit currently presented
//  DOT_OUT         out  1   dot flag of the digit currently presented
//  FRAME_TICK_OUT  out  1   1-cycle pulse on the edge where the index wraps 3->0
//  BUSY_OUT        out  1   1 = loaded data is pending and not yet committed
// BEHAVIOUR
//  Reset, synchronous and dominant over all other inputs, clears:
//   - prescaler, index, active digits/dots and pending buffer to 0; pending flag to 0
//   - outputs SEG_SELECT_OUT=0, BIN_OUT=0, DOT_OUT=0, FRAME_TICK_OUT=0, BUSY_OUT=0
//   - any LOAD in the reset cycle is ignored; uncommitted pending data is discarded
//  Prescaler:
//   - counts 0..CLK_DIV-1 while ENABLE=1; internal tick when count==CLK_DIV-1 and ENABLE=1
//   - count returns to 0 on tick; ENABLE=0 holds count and index unchanged
//  Index: on tick, idx <= idx+1 mod 4 (3 wraps to 0).
//  Load:
//   - LOAD=1 (independent of ENABLE) writes the pending buffer and sets the pending flag
//   - multiple LOADs before a commit: the last one wins
//  Commit, on the tick with idx==3 (the wrap edge):
//   - if the pending flag was set before the edge: active <= pending buffer, flag cleared
//   - if LOAD coincides with the commit edge: commit uses the pre-edge buffer contents;
//     the new data is captured into the buffer and the flag stays 1
//   - with no pending data, active registers are unchanged
//  Outputs (all registered and mutually consistent; no cycle with mixed index/data):
//   - on a tick edge, SEG_SELECT_OUT = new idx; BIN_OUT/DOT_OUT = that digit of the
//     post-commit active registers; i.e. the digit change appears with 0 cycles of skew
//   - FRAME_TICK_OUT = 1 for exactly the cycle after the wrap edge
//   - BUSY_OUT mirrors the pending flag (rises the cycle after LOAD)
//  Loaded data is visible within <= 4*CLK_DIV enabled cycles after LOAD.
//  ENABLE=0 with a pending load: nothing commits until scanning resumes and the index wraps.
//  Width rules: index arithmetic is 2-bit modulo; prescaler width = clog2(CLK_DIV), minimum 1.
// STRUCTURE
//  Shared display package/header:
//   - NUM_DIGITS=4, DIGIT_W=4, SEL_W=2, default refresh divisor; reused by the decoder and
//     by the traffic-light timer
//  Sub-module refresh_prescaler (CLK, RESET, ENABLE -> TICK_OUT), parameter CLK_DIV.
//  Top level holds the index, pending/active buffers, commit logic and output registers.
// TESTING (CLK_DIV=4)
//  1 RESET 2 cycles, ENABLE=1 -> all outputs 0; SEG_SELECT_OUT=1 exactly 4 cycles after release.
//  2 LOAD 16'h1234, DOTS 4'b0001 at idx1 -> BIN stays 0 until wrap; FRAME_TICK_OUT pulses; then
//    idx0..3 show BIN 4,3,2,1 with DOT 1,0,0,0; BUSY_OUT 1->0 at that wrap.
//  3 LOAD 16'hAAAA then 16'h5555 in one frame -> only 5 shown on every digit; A never appears.
//  4 LOAD 16'hBEEF on the commit edge while 16'h1111 pending -> frame shows 1s, BUSY_OUT stays 1;
//    next frame shows F,E,E,B.
//  5 ENABLE=0 for 20 cycles mid-frame -> outputs constant, no FRAME_TICK_OUT; resume continues
//    the same count.
//  6 RESET asserted while 16'h9999 pending -> BUSY_OUT=0, BIN_OUT=0; no 9 shown afterwards.

Source files
------------

// File: rtl/seg_display_pkg.sv
// Shared 7-segment display definitions: digit geometry, default refresh divisor and
// the double-buffered frame record used by the scan driver.
package seg_display_pkg;

  localparam int unsigned NUM_DIGITS      = 4;
  localparam int unsigned DIGIT_W         = 4;
  localparam int unsigned SEL_W           = 2;
  localparam int unsigned DEFAULT_CLK_DIV = 100000;

  typedef logic [SEL_W-1:0]   seg_sel_t;
  typedef logic [DIGIT_W-1:0] digit_t;

  typedef struct packed {
    logic [NUM_DIGITS*DIGIT_W-1:0] digits;
    logic [NUM_DIGITS-1:0]         dots;
  } frame_t;

  // Counter width for a divide-by-div prescaler; a divisor of 1 still needs one bit.
  function automatic int unsigned prescale_width(int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  function automatic digit_t frame_digit(frame_t f, seg_sel_t sel);
    return f.digits[sel*DIGIT_W +: DIGIT_W];
  endfunction

  function automatic logic frame_dot(frame_t f, seg_sel_t sel);
    return f.dots[sel];
  endfunction

endpackage

// File: rtl/seg_display_scanner_prescaler.sv
// Refresh-rate prescaler: pulses TICK_OUT on the last enabled cycle of every CLK_DIV.
module refresh_prescaler
  import seg_display_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE,
  output logic TICK_OUT
);

  localparam int unsigned    CntW   = prescale_width(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;

  always_comb begin
    TICK_OUT = ENABLE && (count_q == CntMax);
    count_d  = count_q;
    if (ENABLE) begin
      count_d = TICK_OUT ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Time-multiplexed 4-digit scan driver with double-buffered, tear-free frame updates.
module seg_display_scanner
  import seg_display_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          ENABLE,
  input  logic                          LOAD,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] DIGITS_IN,
  input  logic [NUM_DIGITS-1:0]         DOTS_IN,
  output logic [SEL_W-1:0]              SEG_SELECT_OUT,
  output logic [DIGIT_W-1:0]            BIN_OUT,
  output logic                          DOT_OUT,
  output logic                          FRAME_TICK_OUT,
  output logic                          BUSY_OUT
);

  localparam seg_sel_t LastIdx = SEL_W'(NUM_DIGITS - 1);

  logic     tick;
  logic     wrap;
  seg_sel_t idx_q, idx_d;
  frame_t   pend_q, pend_d;
  frame_t   act_q, act_d;
  logic     pend_valid_q, pend_valid_d;
  seg_sel_t sel_q, sel_d;
  digit_t   bin_q, bin_d;
  logic     dot_q, dot_d;
  logic     frame_q, frame_d;

  refresh_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .CLK      (CLK),
    .RESET    (RESET),
    .ENABLE   (ENABLE),
    .TICK_OUT (tick)
  );

  always_comb begin
    wrap         = tick && (idx_q == LastIdx);
    idx_d        = idx_q;
    pend_d       = pend_q;
    act_d        = act_q;
    pend_valid_d = pend_valid_q;
    sel_d        = sel_q;
    bin_d        = bin_q;
    dot_d        = dot_q;
    frame_d      = wrap;

    // Commit uses the pre-edge buffer, so a LOAD on the wrap edge lands in the next frame.
    if (wrap && pend_valid_q) begin
      act_d        = pend_q;
      pend_valid_d = 1'b0;
    end

    if (LOAD) begin
      pend_d       = '{digits: DIGITS_IN, dots: DOTS_IN};
      pend_valid_d = 1'b1;
    end

    // Index and data move together on the tick edge, from the post-commit frame.
    if (tick) begin
      idx_d = idx_q + 1'b1;
      sel_d = idx_d;
      bin_d = frame_digit(act_d, idx_d);
      dot_d = frame_dot(act_d, idx_d);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      idx_q        <= '0;
      pend_q       <= '0;
      act_q        <= '0;
      pend_valid_q <= 1'b0;
      sel_q        <= '0;
      bin_q        <= '0;
      dot_q        <= 1'b0;
      frame_q      <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      act_q        <= act_d;
      pend_valid_q <= pend_valid_d;
      sel_q        <= sel_d;
      bin_q        <= bin_d;
      dot_q        <= dot_d;
      frame_q      <= frame_d;
    end
  end

  always_comb begin
    SEG_SELECT_OUT = sel_q;
    BIN_OUT        = bin_q;
    DOT_OUT        = dot_q;
    FRAME_TICK_OUT = frame_q;
    BUSY_OUT       = pend_valid_q;
  end

endmodule

// File: tb/tb_seg_display_scanner.sv
// Scenario and randomized bench for seg_display_scanner against a frame-level reference model.
module tb_seg_display_scanner;

  localparam int DIV = 4;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        load;
  logic [15:0] digits_in;
  logic [3:0]  dots_in;
  logic [1:0]  sel_out;
  logic [3:0]  bin_out;
  logic        dot_out;
  logic        frame_out;
  logic        busy_out;

  int total = 0;
  int bad   = 0;

  // Reference model: enabled-cycle position inside a 4*DIV-cycle frame plus the two buffers.
  int          m_cnt;
  bit          m_pv;
  logic [15:0] m_pd, m_ad;
  logic [3:0]  m_pdt, m_adt;
  bit          m_frame;

  seg_display_scanner #(
    .CLK_DIV (DIV)
  ) dut (
    .CLK            (clk),
    .RESET          (reset),
    .ENABLE         (enable),
    .LOAD           (load),
    .DIGITS_IN      (digits_in),
    .DOTS_IN        (dots_in),
    .SEG_SELECT_OUT (sel_out),
    .BIN_OUT        (bin_out),
    .DOT_OUT        (dot_out),
    .FRAME_TICK_OUT (frame_out),
    .BUSY_OUT       (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int exp_sel();
    return m_cnt / DIV;
  endfunction

  function automatic logic [3:0] exp_bin();
    return m_ad[exp_sel()*4 +: 4];
  endfunction

  function automatic logic exp_dot();
    return m_adt[exp_sel()];
  endfunction

  // True when the next enabled edge is the 3->0 wrap.
  function automatic bit at_wrap_edge();
    return m_cnt == 4 * DIV - 1;
  endfunction

  task automatic drive_cycle(input bit r, input bit e, input bit l,
                             input logic [15:0] d, input logic [3:0] dt);
    bit wrap;
    reset     = r;
    enable    = e;
    load      = l;
    digits_in = d;
    dots_in   = dt;
    @(posedge clk);
    if (r) begin
      m_cnt = 0; m_pv = 0; m_pd = '0; m_pdt = '0; m_ad = '0; m_adt = '0; m_frame = 0;
    end else begin
      m_frame = 0;
      if (e) begin
        wrap  = at_wrap_edge();
        m_cnt = (m_cnt + 1) % (4 * DIV);
        if (wrap) begin
          m_frame = 1;
          if (m_pv) begin
            m_ad = m_pd; m_adt = m_pdt; m_pv = 0;
          end
        end
      end
      if (l) begin
        m_pd = d; m_pdt = dt; m_pv = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive_cycle(1, 1, 1, 16'hFFFF, 4'hF);
    drive_cycle(1, 1, 1, 16'hFFFF, 4'hF);
    total++;
    if (sel_out !== 2'd0 || bin_out !== 4'd0 || dot_out !== 1'b0 || frame_out !== 1'b0 ||
        busy_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got sel=%0d bin=%h dot=%b frame=%b busy=%b want all 0",
               sel_out, bin_out, dot_out, frame_out, busy_out);
    end
    for (int i = 1; i <= 4; i++) begin
      drive_cycle(0, 1, 0, '0, '0);
      if (i == 3 || i == 4) begin
        total++;
        if (sel_out !== ((i == 4) ? 2'd1 : 2'd0)) begin
          bad++;
          $display("FAIL first_step: cycle %0d got sel=%0d want %0d", i, sel_out,
                   (i == 4) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_load_commit();
    logic [3:0] seen_bin [4];
    logic       seen_dot [4];
    int         phase = 0;
    for (int i = 0; i < 4; i++) begin seen_bin[i] = 'x; seen_dot[i] = 1'bx; end
    for (int i = 0; i < 64 && exp_sel() != 1; i++) drive_cycle(0, 1, 0, '0, '0);
    drive_cycle(0, 1, 1, 16'h1234, 4'b0001);
    for (int i = 0; i < 10 * DIV && phase < 2; i++) begin
      drive_cycle(0, 1, 0, '0, '0);
      total++;
      if (sel_out !== 2'(exp_sel()) || bin_out !== exp_bin() || dot_out !== exp_dot() ||
          frame_out !== m_frame || busy_out !== m_pv) begin
        bad++;
        $display("FAIL load_commit: got sel=%0d bin=%h dot=%b frame=%b busy=%b want %0d %h %b %b %b",
                 sel_out, bin_out, dot_out, frame_out, busy_out,
                 exp_sel(), exp_bin(), exp_dot(), m_frame, m_pv);
      end
      if (frame_out === 1'b1) begin
        if (phase == 0) begin
          total++;
          if (busy_out !== 1'b0) begin
            bad++;
            $display("FAIL busy_fall: got busy=%b want 0 at commit wrap", busy_out);
          end
        end
        phase++;
      end
      if (phase == 0) begin
        total++;
        if (bin_out !== 4'h0 || busy_out !== 1'b1) begin
          bad++;
          $display("FAIL pre_commit: got bin=%h busy=%b want bin=0 busy=1", bin_out, busy_out);
        end
      end else if (phase == 1) begin
        seen_bin[sel_out] = bin_out;
        seen_dot[sel_out] = dot_out;
      end
    end
    total++;
    if (phase < 2 || seen_bin[0] !== 4'h4 || seen_bin[1] !== 4'h3 || seen_bin[2] !== 4'h2 ||
        seen_bin[3] !== 4'h1 || seen_dot[0] !== 1'b1 || seen_dot[1] !== 1'b0 ||
        seen_dot[2] !== 1'b0 || seen_dot[3] !== 1'b0) begin
      bad++;
      $display("FAIL frame_1234: wraps=%0d got bins %h %h %h %h dots %b%b%b%b want 4 3 2 1 dots 1000",
               phase, seen_bin[0], seen_bin[1], seen_bin[2], seen_bin[3],
               seen_dot[0], seen_dot[1], seen_dot[2], seen_dot[3]);
    end
  endtask

  task automatic test_last_wins();
    int wraps = 0;
    for (int i = 0; i < 64 && exp_sel() != 0; i++) drive_cycle(0, 1, 0, '0, '0);
    drive_cycle(0, 1, 1, 16'hAAAA, 4'hA);
    drive_cycle(0, 1, 1, 16'h5555, 4'h5);
    for (int i = 0; i < 10 * DIV; i++) begin
      drive_cycle(0, 1, 0, '0, '0);
      if (frame_out === 1'b1) wraps++;
      total++;
      if (sel_out !== 2'(exp_sel()) || bin_out !== exp_bin() || dot_out !== exp_dot() ||
          frame_out !== m_frame || busy_out !== m_pv || bin_out === 4'hA ||
          (wraps > 0 && bin_out !== 4'h5)) begin
        bad++;
        $display("FAIL last_wins: wraps=%0d got sel=%0d bin=%h dot=%b busy=%b want %0d %h %b %b",
                 wraps, sel_out, bin_out, dot_out, busy_out, exp_sel(), exp_bin(), exp_dot(),
                 m_pv);
      end
    end
  endtask

  task automatic test_commit_collision();
    logic [3:0] beef_exp [4];
    beef_exp[0] = 4'hF; beef_exp[1] = 4'hE; beef_exp[2] = 4'hE; beef_exp[3] = 4'hB;
    for (int i = 0; i < 64 && exp_sel() != 0; i++) drive_cycle(0, 1, 0, '0, '0);
    drive_cycle(0, 1, 1, 16'h1111, 4'h0);
    for (int i = 0; i < 64 && !at_wrap_edge(); i++) drive_cycle(0, 1, 0, '0, '0);
    drive_cycle(0, 1, 1, 16'hBEEF, 4'h0);
    total++;
    if (frame_out !== 1'b1 || busy_out !== 1'b1 || sel_out !== 2'd0 || bin_out !== 4'h1) begin
      bad++;
      $display("FAIL collide_edge: got frame=%b busy=%b sel=%0d bin=%h want 1 1 0 1",
               frame_out, busy_out, sel_out, bin_out);
    end
    for (int i = 1; i < 8 * DIV; i++) begin
      drive_cycle(0, 1, 0, '0, '0);
      total++;
      if (sel_out !== 2'(exp_sel()) || bin_out !== exp_bin() || busy_out !== m_pv ||
          bin_out !== ((i < 4 * DIV) ? 4'h1 : beef_exp[sel_out]) ||
          busy_out !== (i < 4 * DIV)) begin
        bad++;
        $display("FAIL collide_frames: i=%0d got sel=%0d bin=%h busy=%b want bin=%h busy=%b",
                 i, sel_out, bin_out, busy_out,
                 (i < 4 * DIV) ? 4'h1 : beef_exp[sel_out], (i < 4 * DIV));
      end
    end
  endtask

  task automatic test_enable_pause();
    int remain;
    int steps = -1;
    for (int i = 0; i < 64 && !(exp_sel() == 2 && m_cnt % DIV == 1); i++)
      drive_cycle(0, 1, 0, '0, '0);
    remain = DIV - (m_cnt % DIV);
    for (int i = 0; i < 20; i++) begin
      drive_cycle(0, 0, 0, '0, '0);
      total++;
      if (sel_out !== 2'd2 || bin_out !== exp_bin() || dot_out !== exp_dot() ||
          frame_out !== 1'b0) begin
        bad++;
        $display("FAIL pause: got sel=%0d bin=%h dot=%b frame=%b want 2 %h %b 0",
                 sel_out, bin_out, dot_out, frame_out, exp_bin(), exp_dot());
      end
    end
    for (int i = 1; i <= 2 * DIV && steps < 0; i++) begin
      drive_cycle(0, 1, 0, '0, '0);
      if (sel_out === 2'd3) steps = i;
    end
    total++;
    if (steps != remain) begin
      bad++;
      $display("FAIL resume: step after %0d cycles want %0d", steps, remain);
    end
  endtask

  task automatic test_reset_pending();
    drive_cycle(0, 1, 1, 16'h9999, 4'hF);
    drive_cycle(1, 1, 0, '0, '0);
    total++;
    if (busy_out !== 1'b0 || bin_out !== 4'h0 || sel_out !== 2'd0 || dot_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_pending: got busy=%b bin=%h sel=%0d dot=%b want 0 0 0 0",
               busy_out, bin_out, sel_out, dot_out);
    end
    for (int i = 0; i < 12 * DIV; i++) begin
      drive_cycle(0, 1, 0, '0, '0);
      total++;
      if (bin_out !== 4'h0 || busy_out !== 1'b0 || sel_out !== 2'(exp_sel())) begin
        bad++;
        $display("FAIL no_stale: got bin=%h busy=%b sel=%0d want 0 0 %0d",
                 bin_out, busy_out, sel_out, exp_sel());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      drive_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 9) == 0, 16'($urandom), 4'($urandom));
      total++;
      if (sel_out !== 2'(exp_sel()) || bin_out !== exp_bin() || dot_out !== exp_dot() ||
          frame_out !== m_frame || busy_out !== m_pv) begin
        bad++;
        $display("FAIL random: cycle %0d got sel=%0d bin=%h dot=%b frame=%b busy=%b want %0d %h %b %b %b",
                 i, sel_out, bin_out, dot_out, frame_out, busy_out,
                 exp_sel(), exp_bin(), exp_dot(), m_frame, m_pv);
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; digits_in = '0; dots_in = '0;
    m_cnt = 0; m_pv = 0; m_pd = '0; m_pdt = '0; m_ad = '0; m_adt = '0; m_frame = 0;
    #1;
    test_reset();
    test_load_commit();
    test_last_wins();
    test_commit_collision();
    test_enable_pause();
    test_reset_pending();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
